// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, default bit period and frame size.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 868;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned STATE_W          = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_START     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA      = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP      = 3'd3;
  localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, valid/ready output, framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned CNT_W        = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic                 rx_s;
  logic [STATE_W-1:0]   state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_valid_n, frame_err_n, overrun_n, busy_n;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
      busy      <= busy_n;
    end
  end

  // Next state, counter and registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    rx_data_n   = rx_data;
    rx_valid_n  = rx_valid & ~rx_ready;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      // Half-period check rejects glitches and centres later samples.
      ST_START: begin
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_n = ST_IDLE;
          end else begin
            state_n   = ST_DATA;
            bit_idx_n = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(DATA_BITS - 1)) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            rx_data_n  = shreg;
            rx_valid_n = 1'b1;
            overrun_n  = rx_valid & ~rx_ready;
            state_n    = ST_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = ST_WAIT_IDLE;
          end
        end
      end
      // Hold off until the line returns high so a break is not re-framed.
      ST_WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    if (state_n != state) cnt_n = '0;
    busy_n = (state_n != ST_IDLE);
  end

endmodule
